// File: rtl/countdown_timer.sv
// Cascaded BCD countdown timer (MM:SS.cc) with load clamping, pause/resume and a one-cycle expiry pulse.
// Optional feature: define CD_AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [23:0] cnt_out,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        logic [3:0] r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Tens of minutes and tens of seconds stop at 5; every other digit stops at 9.
    function automatic logic [23:0] clamp_bcd(input logic [23:0] v);
        return {clamp_digit(v[23:20], 4'd5), clamp_digit(v[19:16], 4'd9),
                clamp_digit(v[15:12], 4'd5), clamp_digit(v[11:8],  4'd9),
                clamp_digit(v[7:4],   4'd9), clamp_digit(v[3:0],   4'd9)};
    endfunction

    // Subtract one centisecond; a zero digit wraps to its maximum and passes the borrow upward.
    function automatic logic [23:0] dec_bcd(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  d;
        logic [3:0]  lim;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = v[i*4 +: 4];
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (d == 4'd0) begin
                    r[i*4 +: 4] = lim;
                end else begin
                    r[i*4 +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = d;
            end
        end
        return r;
    endfunction

    state_t      state_r;
    logic [23:0] cnt_r;
    logic [PW-1:0] presc_r;
    logic        running_r;
    logic        done_r;
`ifdef CD_AUTO_RELOAD_EN
    logic [23:0] preset_r;
`endif

    logic [23:0] load_clamped_s;
    logic [23:0] cnt_dec_s;
    logic        cnt_zero_s;
    logic        dec_zero_s;
    logic        tick_s;

    assign load_clamped_s = clamp_bcd(load_val);
    assign cnt_dec_s      = dec_bcd(cnt_r);
    assign cnt_zero_s     = (cnt_r == 24'h000000);
    assign dec_zero_s     = (cnt_dec_s == 24'h000000);
    assign tick_s         = (presc_r == PRESC_LAST);

    // Control FSM, count, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 24'h000000;
            presc_r   <= PRESC_ZERO;
            running_r <= 1'b0;
            done_r    <= 1'b0;
`ifdef CD_AUTO_RELOAD_EN
            preset_r  <= 24'h000000;
`endif
        end else begin
            done_r <= 1'b0;
            if (load) begin
                // Load overrides every state and always lands in IDLE.
                state_r   <= ST_IDLE;
                cnt_r     <= load_clamped_s;
                running_r <= 1'b0;
`ifdef CD_AUTO_RELOAD_EN
                preset_r  <= load_clamped_s;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!pause && start && !cnt_zero_s) begin
                            state_r   <= ST_RUN;
                            presc_r   <= PRESC_ZERO;
                            running_r <= 1'b1;
                        end else begin
                            running_r <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            // Prescaler is left as-is so a suppressed tick fires right after resume.
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end else if (tick_s) begin
                            presc_r <= PRESC_ZERO;
                            if (dec_zero_s) begin
`ifdef CD_AUTO_RELOAD_EN
                                cnt_r     <= preset_r;
                                done_r    <= 1'b1;
                                running_r <= 1'b1;
`else
                                cnt_r     <= cnt_dec_s;
                                state_r   <= ST_DONE;
                                done_r    <= 1'b1;
                                running_r <= 1'b0;
`endif
                            end else begin
                                cnt_r     <= cnt_dec_s;
                                running_r <= 1'b1;
                            end
                        end else begin
                            presc_r   <= presc_r + PRESC_ONE;
                            running_r <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause && start) begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end else begin
                            running_r <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_out = cnt_r;
    assign running = running_r;
    assign done    = done_r;

endmodule
